// File: rtl/rv_scoreboard_if.sv
// rv_scoreboard_if: decode/writeback handshake bundle for the register scoreboard.
//   master : decode/fetch/writeback side (drives instruction, redirect, cache and wb strobes)
//   slave  : scoreboard side (drives stall, cause, busy vector and debug flags)
interface rv_scoreboard_if #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NWB   = 2
);
  logic              id_valid;
  logic [AW-1:0]     id_rs1, id_rs2, id_rs3;
  logic [2:0]        id_rs_used;      // {rs3,rs2,rs1}
  logic [AW-1:0]     id_rd;
  logic              id_rd_wr;
  logic              id_long;
  logic              id_store;
  logic              pc_change;
  logic              i_ready;
  logic              d_ready;
  logic [NWB-1:0]    wb_valid;
  logic [NWB*AW-1:0] wb_rd;           // port k at [k*AW +: AW]
  logic              PC_Stall;
  logic              NOP_Ins;
  logic [3:0]        stall_cause;     // {redirect, store, structural, data}
  logic [NREGS-1:0]  busy_o;
  logic              stall_timeout;
  logic              wb_err;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs3, id_rs_used, id_rd, id_rd_wr,
           id_long, id_store, pc_change, i_ready, d_ready, wb_valid, wb_rd,
    input  PC_Stall, NOP_Ins, stall_cause, busy_o, stall_timeout, wb_err
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs3, id_rs_used, id_rd, id_rd_wr,
           id_long, id_store, pc_change, i_ready, d_ready, wb_valid, wb_rd,
    output PC_Stall, NOP_Ins, stall_cause, busy_o, stall_timeout, wb_err
  );
endinterface

// File: rtl/rv_scoreboard.sv
// rv_scoreboard: decode-stage busy-register scoreboard and hazard/stall controller.
// Tracks destinations of in-flight long-latency ops, stalls issue on RAW/WAW,
// on a full pending pool, during a redirect and while a store is outstanding.
//   CLK, rst_n : clock (rising edge), asynchronous active-low reset
//   sb         : rv_scoreboard_if.slave -- decode inputs, writeback strobes,
//                PC_Stall/NOP_Ins, stall_cause, busy_o, stall_timeout, wb_err
module rv_scoreboard #(
  parameter int NREGS     = 32,
  parameter int AW        = 5,
  parameter int NWB       = 2,
  parameter int MAX_PEND  = 4,
  parameter int WB_BYPASS = 1,
  parameter int TO_W      = 8,
  parameter int TIMEOUT   = 200
) (
  input logic         CLK,
  input logic         rst_n,
  rv_scoreboard_if.slave sb
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REDIR = 2'd1, S_STORE = 2'd2} state_t;

  state_t           r_state, w_state_nxt;
  logic [NREGS-1:0] r_busy, w_busy_nxt, w_clr, w_eff, w_set;
  logic [TO_W-1:0]  r_wd, w_wd_nxt;
  logic             r_to, r_err;
  logic             w_wb_bad, w_data, w_struct, w_stall, w_fire;
  logic [3:0]       w_cause;
  int               w_pend;

  // Index 0 and out-of-range indices never hazard.
  function automatic logic hz(input logic [AW-1:0] idx, input logic [NREGS-1:0] v);
    return (idx != '0) && (int'(idx) < NREGS) && v[idx];
  endfunction

  // Writeback clear mask; duplicate ports on one register just OR together.
  // A strobe naming a non-busy (or zero / out-of-range) register flags wb_err.
  always_comb begin
    logic [AW-1:0] idx;
    idx      = '0;
    w_clr    = '0;
    w_wb_bad = 1'b0;
    for (int k = 0; k < NWB; k++) begin
      idx = sb.wb_rd[k*AW +: AW];
      if (sb.wb_valid[k]) begin
        if (int'(idx) < NREGS) begin
          w_clr[idx] = 1'b1;
          if (!r_busy[idx]) w_wb_bad = 1'b1;
        end else begin
          w_wb_bad = 1'b1;
        end
      end
    end
    w_clr[0] = 1'b0;
  end

  assign w_eff = (WB_BYPASS != 0) ? (r_busy & ~w_clr) : r_busy;

  always_comb begin
    w_pend = 0;
    for (int r = 0; r < NREGS; r++) w_pend += int'(r_busy[r]);
  end

  assign w_data = sb.id_valid && (
                    (sb.id_rs_used[0] && hz(sb.id_rs1, w_eff)) ||
                    (sb.id_rs_used[1] && hz(sb.id_rs2, w_eff)) ||
                    (sb.id_rs_used[2] && hz(sb.id_rs3, w_eff)) ||
                    (sb.id_rd_wr      && hz(sb.id_rd,  w_eff)));

  // Structural uses the registered pool size: a same-cycle writeback frees a
  // slot only from the next cycle on.
  assign w_struct = sb.id_valid && sb.id_long && sb.id_rd_wr && (sb.id_rd != '0) &&
                    (w_pend == MAX_PEND);

  assign w_cause = {r_state == S_REDIR, r_state == S_STORE, w_struct, w_data};
  assign w_stall = |w_cause;
  assign w_fire  = sb.id_valid && !w_stall;

  always_comb begin
    w_set = '0;
    if (w_fire && sb.id_long && sb.id_rd_wr && (sb.id_rd != '0) && (int'(sb.id_rd) < NREGS))
      w_set[sb.id_rd] = 1'b1;
    // Set wins over a coincident clear.
    w_busy_nxt    = (r_busy & ~w_clr) | w_set;
    w_busy_nxt[0] = 1'b0;
  end

  // Control FSM next state; a redirect overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (sb.id_valid && sb.id_store && !w_stall) w_state_nxt = S_STORE;
      S_REDIR: if (sb.i_ready) w_state_nxt = S_IDLE;
      S_STORE: if (sb.d_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (sb.pc_change) w_state_nxt = S_REDIR;
  end

  always_comb begin
    if (!w_stall)        w_wd_nxt = '0;
    else if (&r_wd)      w_wd_nxt = r_wd;
    else                 w_wd_nxt = r_wd + 1'b1;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_wd   <= '0;
      r_to   <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_wd   <= w_wd_nxt;
      // Timeout flags on the edge the counter reaches TIMEOUT.
      r_to   <= r_to  | (w_wd_nxt == TO_W'(TIMEOUT));
      r_err  <= r_err | w_wb_bad;
    end
  end

  assign sb.stall_cause   = w_cause;
  assign sb.PC_Stall      = w_stall;
  assign sb.NOP_Ins       = w_stall;
  assign sb.busy_o        = r_busy;
  assign sb.stall_timeout = r_to;
  assign sb.wb_err        = r_err;

endmodule

// File: tb/tb_rv_scoreboard.sv
// tb_rv_scoreboard: directed scenarios plus randomized traffic against a
// behavioural scoreboard model (busy set, redirect/store flags, stall counter).
module tb_rv_scoreboard;
  localparam int NREGS = 32, AW = 5, NWB = 2, MAXP = 4, BYP = 1, TMO = 10;

  logic CLK, rst_n;
  int   n_chk = 0, n_err = 0;

  rv_scoreboard_if #(.NREGS(NREGS), .AW(AW), .NWB(NWB)) sb ();

  rv_scoreboard #(.NREGS(NREGS), .AW(AW), .NWB(NWB), .MAX_PEND(MAXP),
                  .WB_BYPASS(BYP), .TO_W(8), .TIMEOUT(TMO))
    dut (.CLK(CLK), .rst_n(rst_n), .sb(sb.slave));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #400000;
    $display("FAIL sim_time_limit obs=running exp=finished");
    $fatal(1);
  end

  // model state
  bit   mb [NREGS];
  bit   clr[NREGS];
  bit   m_redir, m_store, m_to, m_err;
  int   m_cnt;
  logic [3:0] e_cause;
  bit   e_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int wbi(int k);
    return int'(sb.wb_rd[k*AW +: AW]);
  endfunction

  function automatic bit hz(int i);
    return (i != 0) && mb[i] && !(BYP != 0 && clr[i]);
  endfunction

  function automatic int npend();
    int n = 0;
    foreach (mb[r]) n += int'(mb[r]);
    return n;
  endfunction

  task automatic model_reset();
    foreach (mb[r]) mb[r] = 1'b0;
    m_redir = 0; m_store = 0; m_to = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_eval();
    bit d, s;
    foreach (clr[r]) clr[r] = 1'b0;
    for (int k = 0; k < NWB; k++) if (sb.wb_valid[k]) clr[wbi(k)] = 1'b1;
    d = sb.id_valid && ((sb.id_rs_used[0] && hz(int'(sb.id_rs1))) ||
                        (sb.id_rs_used[1] && hz(int'(sb.id_rs2))) ||
                        (sb.id_rs_used[2] && hz(int'(sb.id_rs3))) ||
                        (sb.id_rd_wr      && hz(int'(sb.id_rd))));
    s = sb.id_valid && sb.id_long && sb.id_rd_wr && sb.id_rd != 0 && npend() == MAXP;
    e_cause = {m_redir, m_store, s, d};
    e_stall = |e_cause;
  endtask

  task automatic model_step();
    bit fire = sb.id_valid && !e_stall;
    for (int k = 0; k < NWB; k++) if (sb.wb_valid[k] && !mb[wbi(k)]) m_err = 1;
    foreach (clr[r]) if (clr[r]) mb[r] = 1'b0;
    if (fire && sb.id_long && sb.id_rd_wr && sb.id_rd != 0) mb[int'(sb.id_rd)] = 1'b1;
    if (sb.pc_change)  begin m_redir = 1; m_store = 0; end
    else if (m_redir)  begin if (sb.i_ready) m_redir = 0; end
    else if (m_store)  begin if (sb.d_ready) m_store = 0; end
    else if (sb.id_valid && sb.id_store && !e_stall) m_store = 1;
    m_cnt = e_stall ? ((m_cnt < 255) ? m_cnt + 1 : 255) : 0;
    if (m_cnt == TMO) m_to = 1;
  endtask

  // Entered at a negedge with inputs applied; leaves at the next negedge.
  task automatic cycle();
    logic [NREGS-1:0] v;
    #1;
    model_eval();
    foreach (mb[r]) v[r] = mb[r];
    chk("cause",    64'(sb.stall_cause),   64'(e_cause));
    chk("pc_stall", 64'(sb.PC_Stall),      64'(e_stall));
    chk("nop_ins",  64'(sb.NOP_Ins),       64'(e_stall));
    chk("busy",     64'(sb.busy_o),        64'(v));
    chk("timeout",  64'(sb.stall_timeout), 64'(m_to));
    chk("wb_err",   64'(sb.wb_err),        64'(m_err));
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic idle_in();
    sb.id_valid = 0; sb.id_rs1 = 0; sb.id_rs2 = 0; sb.id_rs3 = 0; sb.id_rs_used = 0;
    sb.id_rd = 0; sb.id_rd_wr = 0; sb.id_long = 0; sb.id_store = 0;
    sb.pc_change = 0; sb.i_ready = 0; sb.d_ready = 0; sb.wb_valid = 0; sb.wb_rd = 0;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_cause"},   64'(sb.stall_cause),   64'd0);
    chk({pfx, "_stall"},   64'(sb.PC_Stall),      64'd0);
    chk({pfx, "_nop"},     64'(sb.NOP_Ins),       64'd0);
    chk({pfx, "_busy"},    64'(sb.busy_o),        64'd0);
    chk({pfx, "_timeout"}, 64'(sb.stall_timeout), 64'd0);
    chk({pfx, "_wberr"},   64'(sb.wb_err),        64'd0);
  endtask

  // Asynchronous reset pulse starting between edges; outputs must clear at once.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 chk_zero("arst");
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    rst_n = 1'b1;
    idle_in();
  endtask

  task automatic rand_in();
    int q[$];
    sb.id_valid   = ($urandom % 4) != 0;
    sb.id_rs1     = AW'($urandom % 8);
    sb.id_rs2     = AW'($urandom % 8);
    sb.id_rs3     = AW'($urandom % 8);
    sb.id_rs_used = 3'($urandom);
    sb.id_rd      = AW'($urandom % 8);
    sb.id_rd_wr   = ($urandom % 4) != 0;
    sb.id_long    = ($urandom % 2) != 0;
    sb.id_store   = ($urandom % 8) == 0;
    sb.pc_change  = ($urandom % 20) == 0;
    sb.i_ready    = ($urandom % 3) == 0;
    sb.d_ready    = ($urandom % 3) == 0;
    foreach (mb[r]) if (mb[r]) q.push_back(r);
    for (int k = 0; k < NWB; k++) begin
      sb.wb_valid[k] = ($urandom % 3) == 0;
      if (q.size() > 0 && ($urandom % 8) != 0)
        sb.wb_rd[k*AW +: AW] = AW'(q[$urandom % q.size()]);
      else
        sb.wb_rd[k*AW +: AW] = AW'($urandom % 8);
    end
  endtask

  task automatic issue_long(input int rd);
    idle_in();
    sb.id_valid = 1; sb.id_long = 1; sb.id_rd_wr = 1; sb.id_rd = AW'(rd);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    model_reset();
    #3 chk_zero("rst");
    @(negedge CLK);
    @(negedge CLK);
    rst_n = 1'b1;

    // RAW on a divide result, released by a same-cycle writeback
    issue_long(5); cycle();
    idle_in(); sb.id_valid = 1; sb.id_rs1 = 5; sb.id_rs_used = 3'b001;
    #1 chk("t1_raw", 64'(sb.stall_cause), 64'h1);
    cycle(); cycle();
    sb.wb_valid = 2'b01; sb.wb_rd[0 +: AW] = 5;
    #1 chk("t1_bypass", 64'(sb.stall_cause), 64'h0);
    cycle();
    idle_in();
    #1 chk("t1_clear", 64'(sb.busy_o), 64'h0);
    cycle();

    // full pending pool
    do_reset();
    for (int i = 1; i <= 4; i++) begin issue_long(i); cycle(); end
    issue_long(6);
    #1 chk("t2_struct", 64'(sb.stall_cause), 64'h2);
    cycle();
    sb.wb_valid = 2'b10; sb.wb_rd[AW +: AW] = 2;
    cycle();
    issue_long(6);
    #1 chk("t2_issue", 64'(sb.stall_cause), 64'h0);
    cycle();
    idle_in();
    #1 chk("t2_busy", 64'(sb.busy_o), 64'h5A);
    cycle();

    // outstanding store, then a redirect that overrides it
    do_reset();
    idle_in(); sb.id_valid = 1; sb.id_store = 1; cycle();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      #1 chk("t3_store", 64'(sb.stall_cause), 64'h4);
      cycle();
    end
    sb.d_ready = 1; cycle();
    idle_in();
    #1 chk("t3_done", 64'(sb.stall_cause), 64'h0);
    cycle();
    sb.id_valid = 1; sb.id_store = 1; cycle();
    idle_in(); sb.pc_change = 1; cycle();
    sb.pc_change = 0;
    #1 chk("t3_redir", 64'(sb.stall_cause), 64'h8);
    cycle(); cycle();
    sb.i_ready = 1; cycle();
    idle_in();
    #1 chk("t3_redir_done", 64'(sb.stall_cause), 64'h0);
    cycle();

    // duplicate writeback, then writeback to a non-busy register
    do_reset();
    issue_long(7); cycle();
    idle_in(); sb.wb_valid = 2'b11; sb.wb_rd = {AW'(7), AW'(7)}; cycle();
    idle_in();
    #1 chk("t4_clear", 64'(sb.busy_o), 64'h0);
    chk("t4_noerr", 64'(sb.wb_err), 64'h0);
    cycle();
    sb.wb_valid = 2'b01; sb.wb_rd[0 +: AW] = 9; cycle();
    idle_in();
    #1 chk("t4_err", 64'(sb.wb_err), 64'h1);
    cycle();

    // long redirect trips the watchdog
    do_reset();
    sb.pc_change = 1; cycle();
    idle_in();
    for (int i = 0; i < 5; i++) cycle();
    #1 chk("t5_early", 64'(sb.stall_timeout), 64'h0);
    for (int i = 0; i < 7; i++) cycle();
    #1 chk("t5_fire", 64'(sb.stall_timeout), 64'h1);
    sb.i_ready = 1; cycle();
    idle_in(); cycle();
    #1 chk("t5_sticky", 64'(sb.stall_timeout), 64'h1);
    cycle();

    // reset while registers are busy and a store is outstanding
    do_reset();
    for (int i = 4; i <= 7; i++) begin issue_long(i); cycle(); end
    idle_in(); sb.id_valid = 1; sb.id_store = 1; cycle();
    idle_in();
    #1 chk("t6_pre_busy", 64'(sb.busy_o), 64'hF0);
    cycle();
    do_reset();

    // randomized traffic with periodic asynchronous resets
    for (int n = 0; n < 800; n++) begin
      if (n % 160 == 159) do_reset();
      rand_in();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
